video_tim_gen: RTL and testbench

- Parametrised line/frame timing generator. Produces sync, gate and done for one video axis. One instance serves horizontal timing; a second, clocked by the horizontal done pulse as its enable, serves vertical timing.
- Generalises the existing timing block in four ways: configurable counter widths, per-line shadowing of timing values, an in-gate pixel index output, and guaranteed minimum line length with an overrun flag.

---
 rtl/video_tim_gen.sv | 158 +++++++++++++++
 tb/tb_video_tim_gen.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_tim_gen.sv
// Line/frame timing generator for one video axis: sync, gate, done, in-gate pixel index, sticky overrun.
// Define VIDEO_TIM_GEN_POL_EN to add shadowed sync_pol/gate_pol output polarity inputs.
module video_tim_gen #(
    parameter int SW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic [SW-1:0] Tsync,
    input  logic [SW-1:0] Tgdel,
    input  logic [CW-1:0] Tgate,
    input  logic [CW-1:0] Tlen,
`ifdef VIDEO_TIM_GEN_POL_EN
    input  logic          sync_pol,
    input  logic          gate_pol,
`endif
    output logic          sync,
    output logic          gate,
    output logic          done,
    output logic [CW-1:0] gate_idx,
    output logic          ovr
);

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        SYNC = 5'b00010,
        GDEL = 5'b00100,
        GATE = 5'b01000,
        LEN  = 5'b10000
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] pcnt, pcnt_n;
    logic [CW:0]   pcnt_m1;
    logic [CW:0]   lcnt, lcnt_n, lcnt_m1;
    logic [SW-1:0] sh_tgdel, sh_tgdel_n;
    logic [CW-1:0] sh_tgate, sh_tgate_n;
    logic          sh_spol, sh_spol_n, sh_gpol, sh_gpol_n;
    logic          spol_in, gpol_in;
    logic          sync_n, gate_n, done_n, ovr_n, start;
    logic [CW-1:0] idx_n;
    logic          pexp, lexp;

`ifdef VIDEO_TIM_GEN_POL_EN
    assign spol_in = sync_pol;
    assign gpol_in = gate_pol;
`else
    assign spol_in = 1'b0;
    assign gpol_in = 1'b0;
`endif

    // Borrow out of the top bit marks the last cycle of a phase / line.
    assign pcnt_m1 = {1'b0, pcnt} - {{CW{1'b0}}, 1'b1};
    assign lcnt_m1 = lcnt - {{CW{1'b0}}, 1'b1};
    assign pexp    = pcnt_m1[CW];
    assign lexp    = lcnt_m1[CW];

    always_comb begin
        state_n    = state;
        pcnt_n     = pcnt;
        // Line counter saturates once expired so a long gate cannot wrap it.
        lcnt_n     = lcnt[CW] ? lcnt : lcnt_m1;
        sh_tgdel_n = sh_tgdel;
        sh_tgate_n = sh_tgate;
        sh_spol_n  = sh_spol;
        sh_gpol_n  = sh_gpol;
        done_n     = 1'b0;
        ovr_n      = ovr;
        idx_n      = gate_idx;
        start      = 1'b0;
        case (state)
            IDLE: start = 1'b1;
            SYNC: begin
                if (pexp) begin
                    state_n = GDEL;
                    pcnt_n  = CW'(sh_tgdel);
                end else begin
                    pcnt_n  = pcnt_m1[CW-1:0];
                end
            end
            GDEL: begin
                if (pexp) begin
                    state_n = GATE;
                    pcnt_n  = sh_tgate;
                    idx_n   = '0;
                end else begin
                    pcnt_n  = pcnt_m1[CW-1:0];
                end
            end
            GATE: begin
                idx_n  = gate_idx + {{(CW-1){1'b0}}, 1'b1};
                pcnt_n = pcnt_m1[CW-1:0];
                if (pexp) begin
                    idx_n = '0;
                    // Expiring exactly now is an on-time line; already expired is an overrun.
                    if (lexp) begin
                        start  = 1'b1;
                        done_n = 1'b1;
                        ovr_n  = ovr | lcnt[CW];
                    end else begin
                        state_n = LEN;
                    end
                end
            end
            LEN: begin
                if (lexp) begin
                    start  = 1'b1;
                    done_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Tsync and Tlen are consumed on the load edge, so their counters act as their shadows.
        if (start) begin
            state_n    = SYNC;
            pcnt_n     = CW'(Tsync);
            lcnt_n     = {1'b0, Tlen};
            sh_tgdel_n = Tgdel;
            sh_tgate_n = Tgate;
            sh_spol_n  = spol_in;
            sh_gpol_n  = gpol_in;
        end
        sync_n = (state_n == SYNC) ^ sh_spol_n;
        gate_n = (state_n == GATE) ^ sh_gpol_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pcnt     <= '0;
            lcnt     <= '0;
            sh_tgdel <= '0;
            sh_tgate <= '0;
            sh_spol  <= 1'b0;
            sh_gpol  <= 1'b0;
            sync     <= spol_in;
            gate     <= gpol_in;
            done     <= 1'b0;
            gate_idx <= '0;
            ovr      <= 1'b0;
        end else if (ena) begin
            state    <= state_n;
            pcnt     <= pcnt_n;
            lcnt     <= lcnt_n;
            sh_tgdel <= sh_tgdel_n;
            sh_tgate <= sh_tgate_n;
            sh_spol  <= sh_spol_n;
            sh_gpol  <= sh_gpol_n;
            sync     <= sync_n;
            gate     <= gate_n;
            done     <= done_n;
            gate_idx <= idx_n;
            ovr      <= ovr_n;
        end
    end

endmodule

// File: tb/tb_video_tim_gen.sv
// Bench for video_tim_gen: randomized and directed stimulus against a line-position reference model.
module tb_video_tim_gen;
    localparam int SW = 8;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1, ena = 1'b0;
    logic [SW-1:0] Tsync = '0, Tgdel = '0;
    logic [CW-1:0] Tgate = '0, Tlen = '0;
    logic          sync, gate, done, ovr;
    logic [CW-1:0] gate_idx;
`ifdef VIDEO_TIM_GEN_POL_EN
    logic          sync_pol = 1'b0, gate_pol = 1'b0;
`endif

    always #5 clk = ~clk;

    video_tim_gen #(.SW(SW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .Tsync(Tsync), .Tgdel(Tgdel), .Tgate(Tgate), .Tlen(Tlen),
`ifdef VIDEO_TIM_GEN_POL_EN
        .sync_pol(sync_pol), .gate_pol(gate_pol),
`endif
        .sync(sync), .gate(gate), .done(done), .gate_idx(gate_idx), .ovr(ovr)
    );

    int n_vec = 0, n_err = 0, cyc = 0;

    // Model: position p within the current line, with the line's captured parameters.
    bit   m_active, m_done, m_ovr;
    int   m_p, m_a, m_b, m_c, m_len, m_per;
    logic m_spol, m_gpol;

    function automatic logic in_spol();
`ifdef VIDEO_TIM_GEN_POL_EN
        return sync_pol;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic in_gpol();
`ifdef VIDEO_TIM_GEN_POL_EN
        return gate_pol;
`else
        return 1'b0;
`endif
    endfunction

    function void m_start();
        m_active = 1;
        m_p   = 0;
        m_a   = int'(Tsync) + 1;
        m_b   = int'(Tgdel) + 1;
        m_c   = int'(Tgate) + 1;
        m_len = int'(Tlen) + 1;
        m_per = (m_a + m_b + m_c > m_len) ? m_a + m_b + m_c : m_len;
        m_spol = in_spol();
        m_gpol = in_gpol();
    endfunction

    function automatic logic [CW+3:0] expv();
        logic s, g;
        logic [CW-1:0] ix;
        int ab;
        ab = m_a + m_b;
        s  = m_active && (m_p < m_a);
        g  = m_active && (m_p >= ab) && (m_p < ab + m_c);
        ix = g ? CW'(m_p - ab) : '0;
        return {s ^ m_spol, g ^ m_gpol, m_done, m_ovr, ix};
    endfunction

    function automatic logic [CW+3:0] obsv();
        return {sync, gate, done, ovr, gate_idx};
    endfunction

    task tick();
        @(posedge clk);
        if (rst) begin
            m_active = 0; m_p = 0; m_done = 0; m_ovr = 0;
            m_spol = in_spol(); m_gpol = in_gpol();
        end else if (ena) begin
            if (!m_active) begin
                m_start();
                m_done = 0;
            end else begin
                m_p++;
                m_done = 0;
                if (m_p == m_per) begin
                    if (m_a + m_b + m_c > m_len) m_ovr = 1;
                    m_start();
                    m_done = 1;
                end
            end
        end
        #1;
        cyc++;
    endtask

    task set_cfg(input int s, input int d, input int g, input int l);
        Tsync = SW'(s); Tgdel = SW'(d); Tgate = CW'(g); Tlen = CW'(l);
    endtask

    task do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task test_reset();
        rst = 1'b1; ena = 1'b1;
        tick();
        n_vec++;
        if (obsv() !== expv()) begin
            n_err++;
            $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
        end
        rst = 1'b0;
    endtask

    task test_basic();
        set_cfg(1, 2, 3, 11);
        do_reset();
        ena = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_vec++;
            if (obsv() !== expv()) begin
                n_err++;
                $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
            end
        end
    endtask

    task test_ena_gating();
        set_cfg(1, 2, 3, 11);
        do_reset();
        for (int i = 0; i < 60; i++) begin
            ena = (i % 2 == 0);
            tick();
            n_vec++;
            if (obsv() !== expv()) begin
                n_err++;
                $display("FAIL ena_gating cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
            end
        end
    endtask

    task test_overrun();
        set_cfg(1, 1, 7, 5);
        do_reset();
        ena = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_vec++;
            if (obsv() !== expv()) begin
                n_err++;
                $display("FAIL overrun cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
            end
        end
        n_vec++;
        if (ovr !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_sticky got=%b exp=1", ovr);
        end
    endtask

    task test_shadow();
        int max_idx;
        bit seen;
        max_idx = 0; seen = 0;
        set_cfg(1, 2, 3, 11);
        do_reset();
        ena = 1'b1;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            n_vec++;
            if (obsv() !== expv()) begin
                n_err++;
                $display("FAIL shadow_pre cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
            end
            seen = (gate === 1'b1);
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL shadow_wait gate=%b exp=1 within 30 cycles", gate);
        end
        Tgate = CW'(5);
        for (int i = 0; i < 30; i++) begin
            tick();
            n_vec++;
            if (obsv() !== expv()) begin
                n_err++;
                $display("FAIL shadow cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
            end
            if (int'(gate_idx) > max_idx) max_idx = int'(gate_idx);
        end
        n_vec++;
        if (max_idx != 5) begin
            n_err++;
            $display("FAIL shadow_max_idx got=%0d exp=5", max_idx);
        end
    endtask

    task test_reset_mid();
        bit seen;
        seen = 0;
        set_cfg(1, 2, 3, 11);
        do_reset();
        ena = 1'b1;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            seen = (gate === 1'b1) && (gate_idx === CW'(2));
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL reset_mid_wait gate_idx=%0d exp=2 within 30 cycles", gate_idx);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (obsv() !== expv()) begin
            n_err++;
            $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_vec++;
            if (obsv() !== expv()) begin
                n_err++;
                $display("FAIL reset_mid_after cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
            end
        end
    endtask

    task test_zero();
        set_cfg(0, 0, 0, 0);
        do_reset();
        ena = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_vec++;
            if (obsv() !== expv()) begin
                n_err++;
                $display("FAIL zero cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
            end
        end
    endtask

    task test_random();
        set_cfg(1, 1, 3, 10);
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            ena = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0)
                set_cfg($urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 7), $urandom_range(0, 20));
`ifdef VIDEO_TIM_GEN_POL_EN
            if ($urandom_range(0, 24) == 0) begin
                sync_pol = 1'($urandom_range(0, 1));
                gate_pol = 1'($urandom_range(0, 1));
            end
`endif
            tick();
            n_vec++;
            if (obsv() !== expv()) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
            end
        end
        rst = 1'b0;
    endtask

    task test_width();
        int max_idx;
        max_idx = 0;
        set_cfg(2, 1, 4095, 4095);
`ifdef VIDEO_TIM_GEN_POL_EN
        sync_pol = 1'b1;
        gate_pol = 1'b0;
`endif
        do_reset();
        ena = 1'b1;
        for (int i = 0; i < 8400; i++) begin
            tick();
            n_vec++;
            if (obsv() !== expv()) begin
                n_err++;
                $display("FAIL width cyc=%0d got=%h exp=%h", cyc, obsv(), expv());
            end
            if (int'(gate_idx) > max_idx) max_idx = int'(gate_idx);
        end
        n_vec++;
        if (max_idx != 4095 || ovr !== 1'b1) begin
            n_err++;
            $display("FAIL width_final max_idx=%0d ovr=%b exp max_idx=4095 ovr=1", max_idx, ovr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ena_gating();
        test_overrun();
        test_shadow();
        test_reset_mid();
        test_zero();
        test_random();
        test_width();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
